// File: rtl/arbiter_n2_pkg.sv
// Shared types and encodings for the two-client arbiter
// and the request-queue stage that feeds it.
package arbiter_n2_pkg;

  typedef logic [1:0] req_t;
  typedef logic [1:0] gnt_t;

  localparam req_t REQ0  = 2'b01;
  localparam req_t REQ1  = 2'b10;
  localparam req_t REQ01 = 2'b11;

  localparam gnt_t NO_GNT = 2'b00;
  localparam gnt_t GNT0   = 2'b01;
  localparam gnt_t GNT1   = 2'b10;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  // {legal, index}; 2'b11 and NO_GNT both decode as not legal
  function automatic logic [1:0] gnt_idx(input gnt_t g);
    logic [1:0] r;
    r = 2'b00;
    case (g)
      GNT0:    r = 2'b10;
      GNT1:    r = 2'b11;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arbiter_n2_fifo.sv
// Per-client FIFO; full/empty come from the occupancy
// counter, pointers wrap naturally.
module arbiter_n2_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  output logic [DW-1:0]              rdata,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (occ == OW'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/arbiter_n2_reqq.sv
// Request-queue stage: per-client FIFOs drive req, the
// returned grant pops into a registered output slot.
module arbiter_n2_reqq
  import arbiter_n2_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in0_valid,
  output logic                       in0_ready,
  input  logic [DW-1:0]              in0_data,
  input  logic                       in1_valid,
  output logic                       in1_ready,
  input  logic [DW-1:0]              in1_data,
  output req_t                       req,
  input  gnt_t                       gnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic                       out_src,
  output logic [$clog2(DEPTH+1)-1:0] occ0,
  output logic [$clog2(DEPTH+1)-1:0] occ1,
  output logic                       gnt_err
);

  logic [DW-1:0] head0;
  logic [DW-1:0] head1;
  logic          full0;
  logic          full1;
  logic          empty0;
  logic          empty1;
  logic [1:0]    gi;
  logic          slot_free;
  logic          pop0;
  logic          pop1;

  assign gi        = gnt_idx(gnt);
  assign slot_free = ~out_valid | out_ready;
  assign pop0      = gi[1] & ~gi[0] & ~empty0 & slot_free;
  assign pop1      = gi[1] &  gi[0] & ~empty1 & slot_free;

  assign in0_ready = ~full0;
  assign in1_ready = ~full1;
  assign req       = {~empty1, ~empty0};

  arbiter_n2_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (in0_valid),
    .wdata (in0_data),
    .pop   (pop0),
    .rdata (head0),
    .occ   (occ0),
    .full  (full0),
    .empty (empty0)
  );

  arbiter_n2_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (in1_valid),
    .wdata (in1_data),
    .pop   (pop1),
    .rdata (head1),
    .occ   (occ1),
    .full  (full1),
    .empty (empty1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      gnt_err   <= 1'b0;
    end else begin
      if (&gnt) gnt_err <= 1'b1;
      unique case (1'b1)
        pop0: begin
          out_valid <= 1'b1;
          out_data  <= head0;
          out_src   <= 1'b0;
        end
        pop1: begin
          out_valid <= 1'b1;
          out_data  <= head1;
          out_src   <= 1'b1;
        end
        default: begin
          if (out_ready) out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_n2_reqq.sv
// Bench for arbiter_n2_reqq: queue model plus a small
// registered arbiter model driving gnt.
module tb_arbiter_n2_reqq;
  import arbiter_n2_pkg::*;

  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int OW      = $clog2(DEPTH+1);
  localparam int CD_MAX1 = 9;
  localparam int CD_MAX2 = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in0_valid = 1'b0;
  logic          in1_valid = 1'b0;
  logic [DW-1:0] in0_data = '0;
  logic [DW-1:0] in1_data = '0;
  logic          out_ready = 1'b1;
  logic          in0_ready;
  logic          in1_ready;
  logic          out_valid;
  logic          out_src;
  logic          gnt_err;
  logic [DW-1:0] out_data;
  logic [OW-1:0] occ0;
  logic [OW-1:0] occ1;
  req_t          req;
  gnt_t          gnt;
  gnt_t          gnt_q;
  gnt_t          gnt_force = NO_GNT;
  logic          arb_en = 1'b0;
  int            run;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          m_valid;
  logic          m_src;
  logic          m_err;
  logic [DW-1:0] m_data;
  logic [DW:0]   acc_log[$];

  always #5 clk = ~clk;

  assign gnt = arb_en ? gnt_q : gnt_force;

  arbiter_n2_reqq #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .req       (req),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .occ0      (occ0),
    .occ1      (occ1),
    .gnt_err   (gnt_err)
  );

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // arbiter: registered grant, holds when nobody requests,
  // client 0 may keep it CD_MAX1 cycles, client 1 CD_MAX2
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q <= NO_GNT;
      run   <= 0;
    end else if (req != 2'b00) begin
      if ((gnt_q == GNT0 && req[0] && run < CD_MAX1) ||
          (gnt_q == GNT1 && req[1] && run < CD_MAX2)) begin
        run <= run + 1;
      end else if (gnt_q == GNT0 && req[1]) begin
        gnt_q <= GNT1;
        run   <= 1;
      end else if (gnt_q == GNT1 && req[0]) begin
        gnt_q <= GNT0;
        run   <= 1;
      end else begin
        gnt_q <= req[0] ? GNT0 : GNT1;
        run   <= 1;
      end
    end
  end

  // reference: two queues and one output slot
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q0.delete();
      q1.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 1'b0;
      m_err   = 1'b0;
    end else begin
      bit a0, a1, free;
      a0   = in0_valid && (q0.size() < DEPTH);
      a1   = in1_valid && (q1.size() < DEPTH);
      free = !m_valid || out_ready;
      if (gnt == 2'b11) m_err = 1'b1;
      if (gnt == GNT0 && q0.size() != 0 && free) begin
        m_data  = q0.pop_front();
        m_src   = 1'b0;
        m_valid = 1'b1;
      end else if (gnt == GNT1 && q1.size() != 0 && free) begin
        m_data  = q1.pop_front();
        m_src   = 1'b1;
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (a0) q0.push_back(in0_data);
      if (a1) q1.push_back(in1_data);
    end
  end

  always @(posedge clk) begin
    if (rst && out_valid && out_ready)
      acc_log.push_back({out_src, out_data});
  end

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_src", 32'(out_src), 32'(m_src));
    chk("occ0", 32'(occ0), 32'(q0.size()));
    chk("occ1", 32'(occ1), 32'(q1.size()));
    chk("req", 32'(req),
        32'({q1.size() != 0, q0.size() != 0}));
    chk("in0_ready", 32'(in0_ready), 32'(q0.size() != DEPTH));
    chk("in1_ready", 32'(in1_ready), 32'(q1.size() != DEPTH));
    chk("gnt_err", 32'(gnt_err), 32'(m_err));
  end

  initial begin
    int k0, k1;
    tick(2);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_req", 32'(req), 32'(2'b00));
      chk("idle_rdy", 32'({in1_ready, in0_ready}), 32'(2'b11));
      chk("idle_vld", 32'(out_valid), 32'(1'b0));
      chk("idle_occ", 32'({occ1, occ0}), 32'(0));
    end

    arb_en    = 1'b1;
    in0_valid = 1'b1;
    in0_data  = 8'hA5;
    tick(1);
    in0_valid = 1'b0;
    chk("sp_req", 32'(req), 32'(2'b01));
    tick(1);
    chk("sp_gnt", 32'(gnt), 32'(2'b01));
    tick(1);
    chk("sp_vld", 32'(out_valid), 32'(1'b1));
    chk("sp_data", 32'(out_data), 32'(8'hA5));
    chk("sp_src", 32'(out_src), 32'(1'b0));
    chk("sp_req0", 32'(req), 32'(2'b00));
    tick(2);

    arb_en    = 1'b0;
    gnt_force = NO_GNT;
    for (int i = 0; i < 5; i++) begin
      in1_valid = 1'b1;
      in1_data  = DW'(8'h30 + i);
      tick(1);
      if (i == 3) begin
        chk("full_occ", 32'(occ1), 32'(4));
        chk("full_rdy", 32'(in1_ready), 32'(1'b0));
      end
    end
    in1_valid = 1'b0;
    chk("full_5th", 32'(occ1), 32'(4));

    for (int i = 0; i < 4; i++) begin
      in0_valid = 1'b1;
      in0_data  = DW'(8'h40 + i);
      tick(1);
    end
    in0_valid = 1'b0;
    out_ready = 1'b0;
    gnt_force = GNT0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("bp_data", 32'(out_data), 32'(8'h40));
      chk("bp_occ", 32'(occ0), 32'(3));
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick(1);
      chk("bp_pop", 32'(out_data), 32'(8'h40 + i));
      chk("bp_pocc", 32'(occ0), 32'(3 - i));
    end
    tick(1);
    chk("stale_vld", 32'(out_valid), 32'(1'b0));
    gnt_force = GNT1;
    tick(5);
    gnt_force = NO_GNT;
    tick(1);
    chk("drain1", 32'(occ1), 32'(0));

    for (int i = 0; i < 4; i++) begin
      in0_valid = 1'b1;
      in1_valid = 1'b1;
      in0_data  = DW'(8'h10 + i);
      in1_data  = DW'(8'h20 + i);
      tick(1);
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    acc_log.delete();
    arb_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      out_ready = (i % 5 != 2);
      tick(1);
    end
    out_ready = 1'b1;
    tick(3);
    chk("mix_cnt", 32'(acc_log.size()), 32'(8));
    k0 = 0;
    k1 = 0;
    foreach (acc_log[i]) begin
      if (acc_log[i][DW]) begin
        chk("mix_ord1", 32'(acc_log[i][DW-1:0]), 32'(8'h20 + k1));
        k1++;
      end else begin
        chk("mix_ord0", 32'(acc_log[i][DW-1:0]), 32'(8'h10 + k0));
        k0++;
      end
    end

    arb_en    = 1'b0;
    gnt_force = NO_GNT;
    in0_valid = 1'b1;
    in0_data  = 8'h55;
    tick(1);
    in0_valid = 1'b0;
    gnt_force = 2'b11;
    tick(1);
    chk("ill_err", 32'(gnt_err), 32'(1'b1));
    chk("ill_occ", 32'(occ0), 32'(1));
    chk("ill_vld", 32'(out_valid), 32'(1'b0));
    gnt_force = NO_GNT;
    tick(3);
    chk("ill_sticky", 32'(gnt_err), 32'(1'b1));
    gnt_force = GNT0;
    tick(1);
    chk("ill_pop", 32'(out_data), 32'(8'h55));
    gnt_force = NO_GNT;
    tick(1);

    in1_valid = 1'b1;
    in1_data  = 8'h66;
    tick(1);
    in1_data  = 8'h67;
    tick(1);
    in1_valid = 1'b0;
    gnt_force = GNT1;
    tick(1);
    #2 rst = 1'b0;
    #1;
    chk("rst_occ", 32'(occ1), 32'(0));
    chk("rst_vld", 32'(out_valid), 32'(1'b0));
    chk("rst_err", 32'(gnt_err), 32'(1'b0));
    tick(1);
    gnt_force = NO_GNT;
    rst = 1'b1;
    tick(1);
    chk("rel_rdy", 32'({in1_ready, in0_ready}), 32'(2'b11));
    chk("rel_occ", 32'({occ1, occ0}), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbiter_n2_reqq.md
Name: arbiter_n2_reqq

Overview:
- Request-queue stage that feeds the two-client arbiter (arbiter_n2) and consumes its grant.
- Buffers transactions from client 0 and client 1 in per-client FIFOs, and drives the arbiter's req vector from FIFO non-empty status.
- Pops the head of the granted client's FIFO into a registered output slot with valid/ready handshake, tagged with the source client.

Parameters:
- DW, 8, data width of each transaction.
- DEPTH, 4, entries per client FIFO; power of 2, minimum 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- in0_valid  input  1  client 0 push request.
- in0_ready  output  1  client 0 FIFO not full.
- in0_data  input  DW  client 0 payload.
- in1_valid  input  1  client 1 push request.
- in1_ready  output  1  client 1 FIFO not full.
- in1_data  input  DW  client 1 payload.
- req  output  2 (req_t)  bit i = FIFO i non-empty; goes to the arbiter req input.
- gnt  input  2 (gnt_t)  grant from the arbiter, registered there.
- out_valid  output  1  output slot holds data.
- out_ready  input  1  downstream accepts.
- out_data  output  DW  popped payload.
- out_src  output  1  client index of out_data.
- occ0  output  $clog2(DEPTH+1)  client 0 FIFO occupancy.
- occ1  output  $clog2(DEPTH+1)  client 1 FIFO occupancy.
- gnt_err  output  1  sticky flag: illegal grant seen.

Behaviour:
- Reset values (rst low, asynchronous):
  - occ0 = occ1 = 0, all FIFO pointers = 0.
  - out_valid = 0, out_data = 0, out_src = 0, gnt_err = 0.
  - req = 2'b00, in0_ready = in1_ready = 1.
  - FIFO storage is not reset.
- Encodings, from the shared package:
  - REQ0 = 2'b01, REQ1 = 2'b10, REQ01 = 2'b11.
  - GNT0 = 2'b01, GNT1 = 2'b10, NO_GNT = 2'b00.
- Push: inX_ready = (occX != DEPTH), combinational from registered occupancy. A write happens when inX_valid && inX_ready. No bypass; data is never visible on out_* in the same cycle it is pushed.
- req[i] = (occ_i != 0), combinational from registers. This holds the arbiter's req steady within a cycle.
- Output slot free: slot_free = ~out_valid | out_ready.
- Pop/load, evaluated each cycle:
  - If gnt == GNT0 && occ0 != 0 && slot_free: pop FIFO 0 head into out_data, out_src <= 0, out_valid <= 1.
  - GNT1 works the same way with FIFO 1 and out_src <= 1.
  - Otherwise, if out_ready, out_valid <= 0. If out_valid is 0, data holds.
- Latency:
  - Push to req assertion: 1 cycle.
  - Arbiter grant returns 1 cycle later (arbiter state is registered).
  - Earliest out_valid: 3 cycles after the push cycle when the FIFO was empty and the arbiter was IDLE.
- Throughput: one pop per cycle while the grant is held and out_ready is high.
- Stale grant: gnt may name a client whose FIFO just drained, because the arbiter holds its state when req is 0. No pop, no error; out_valid drops once consumed.
- Illegal grant:
  - gnt == 2'b11 is treated as NO_GNT (no pop) and sets gnt_err.
  - gnt_err clears only on reset.
- Simultaneous push and pop on the same FIFO: occupancy unchanged, both pointers advance.
- Full FIFO: a push and pop in the same cycle is impossible, because in_ready was already 0 that cycle; the push is refused.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are decided by occ, not by pointer compare.
- Backpressure: while out_valid && !out_ready, out_data and out_src are held stable and no pop occurs, even with a grant present.
- Reset asserted mid-operation: all state clears immediately and in-flight data is discarded. After release, in_ready = 1 on the first clock.

Decomposition:
- arbiter_n2_pkg (existing) supplies req_t, gnt_t, REQ*/GNT* constants.
- Add to arbiter_n2_pkg: a localparam for the default DEPTH, and a function gnt_idx(gnt_t) returning {legal, index}.
- One sub-module, arbiter_n2_fifo (parameterised DW, DEPTH), with push/pop/occ/full/empty; instantiated twice.
- Top-level holds the output slot, pop steering and gnt_err.

Test Plan:
- Reset then idle: rst low 2 cycles, release. Required: req = 00, in0_ready = in1_ready = 1, out_valid = 0, occ0 = occ1 = 0 for 10 cycles.
- Single push: in0 pushes 0xA5 at cycle 0, arbiter model connected. Required: req = 01 at cycle 1, gnt = 01 at cycle 2, out_valid = 1 with out_data = 0xA5 and out_src = 0 at cycle 3, req = 00 afterwards.
- Fill to full: push 5 entries to client 1 with gnt held at NO_GNT. Required: occ1 = 4, in1_ready = 0 after the 4th push, 5th push refused, occ1 unchanged.
- Backpressure: out_ready = 0 for 4 cycles with gnt = GNT0 and occ0 = 3. Required: out_data stable, occ0 = 3 throughout; after out_ready rises, one pop per cycle.
- Both clients loaded, data 0x10..0x13 and 0x20..0x23, with arbiter CD_MAX1 = 9 and CD_MAX2 = 1. Required: out_src sequence matches the arbiter grant trace, per-client order preserved, no loss or duplication.
- Force gnt = 2'b11 for one cycle. Required: no pop, gnt_err = 1 and stays 1 until rst is low.
